// File: rtl/sfr_wr_arbiter.sv
// Arbitrates CPU and debug-loader SFR writes onto one registered op/byte bus (IDLE -> ISSUE -> ACK).
// Build macro SFR_ARB_CPU_PRIO_EN: simultaneous requests always go to the CPU instead of round-robin.
`ifndef SFR_OP_LEN
`define SFR_OP_LEN 8
`endif

module sfr_wr_arbiter #(
    parameter int OP_W = `SFR_OP_LEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cpu_req,
    input  logic [OP_W-1:0] i_cpu_op,
    input  logic [7:0]      i_cpu_byte,
    output logic            o_cpu_ack,
    input  logic            i_dbg_req,
    input  logic [OP_W-1:0] i_dbg_op,
    input  logic [7:0]      i_dbg_byte,
    output logic            o_dbg_ack,
    output logic [OP_W-1:0] o_op,
    output logic [7:0]      o_byte,
    output logic            o_busy,
    output logic            o_owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            grant_s;
    logic            win_dbg_s;
    logic [OP_W-1:0] op_nxt_s;
    logic [7:0]      byte_nxt_s;
    logic            cpu_ack_nxt_s;
    logic            dbg_ack_nxt_s;
    logic            owner_nxt_s;
    logic            busy_nxt_s;

    assign grant_s = i_cpu_req | i_dbg_req;

    // Tie-break: winner selection among pending requesters
    always_comb begin
        win_dbg_s = 1'b0;
        if (i_cpu_req && i_dbg_req) begin
`ifdef SFR_ARB_CPU_PRIO_EN
            win_dbg_s = 1'b0;
`else
            win_dbg_s = ~o_owner;
`endif
        end else if (i_dbg_req) begin
            win_dbg_s = 1'b1;
        end else begin
            win_dbg_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; requests only matter in IDLE
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_ACK;
            ST_ACK:   state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output next-values; the ack goes to o_owner, which holds the winner for the whole transfer
    always_comb begin
        op_nxt_s      = {OP_W{1'b0}};
        byte_nxt_s    = o_byte;
        cpu_ack_nxt_s = 1'b0;
        dbg_ack_nxt_s = 1'b0;
        owner_nxt_s   = o_owner;
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    op_nxt_s    = win_dbg_s ? i_dbg_op : i_cpu_op;
                    byte_nxt_s  = win_dbg_s ? i_dbg_byte : i_cpu_byte;
                    owner_nxt_s = win_dbg_s;
                end else begin
                    op_nxt_s    = {OP_W{1'b0}};
                    byte_nxt_s  = o_byte;
                    owner_nxt_s = o_owner;
                end
            end
            ST_ISSUE: begin
                cpu_ack_nxt_s = ~o_owner;
                dbg_ack_nxt_s = o_owner;
            end
            ST_ACK: begin
                cpu_ack_nxt_s = 1'b0;
                dbg_ack_nxt_s = 1'b0;
            end
            default: begin
                cpu_ack_nxt_s = 1'b0;
                dbg_ack_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_op      <= {OP_W{1'b0}};
            o_byte    <= 8'h00;
            o_busy    <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_dbg_ack <= 1'b0;
            o_owner   <= 1'b1;
        end else begin
            o_op      <= op_nxt_s;
            o_byte    <= byte_nxt_s;
            o_busy    <= busy_nxt_s;
            o_cpu_ack <= cpu_ack_nxt_s;
            o_dbg_ack <= dbg_ack_nxt_s;
            o_owner   <= owner_nxt_s;
        end
    end

endmodule

// File: doc/sfr_wr_arbiter.md
SFR_WR_ARBITER -- requirements
Module: sfr_wr_arbiter

Interface
REQ-001: Parameter OP_W, default `SFR_OP_LEN, width of the one-hot SFR operation bus.
REQ-002: i_clk  in  1  clock, all state updates on rising edge.
REQ-003: i_rst  in  1  reset, synchronous, active-high.
REQ-004: i_cpu_req  in  1  CPU write request, level; held until o_cpu_ack.
REQ-005: i_cpu_op  in  OP_W  CPU SFR operation; stable while i_cpu_req=1.
REQ-006: i_cpu_byte  in  8  CPU write data; stable while i_cpu_req=1.
REQ-007: o_cpu_ack  out  1  one-cycle pulse, CPU write completed.
REQ-008: i_dbg_req, i_dbg_op[OP_W], i_dbg_byte[8], o_dbg_ack  same rules as CPU port, for the debug loader.
REQ-009: o_op  out  OP_W  operation to SFR registers (e.g. DMOD), registered.
REQ-010: o_byte  out  8  write data to SFR registers, registered.
REQ-011: o_busy  out  1  high in any state other than IDLE.
REQ-012: o_owner  out  1  0 = CPU, 1 = debug; requester of the last grant.

Function
REQ-013: FSM states IDLE, ISSUE, ACK; IDLE->ISSUE on any request, ISSUE->ACK always, ACK->IDLE always.
REQ-014: Requests are sampled only in IDLE; requests arriving in ISSUE/ACK wait.
REQ-015: On grant at edge k, o_op/o_byte carry the winner's op/byte during cycle k+1 (ISSUE) only.
REQ-016: o_op SHALL be all-zero in IDLE and ACK; o_byte holds its last value.
REQ-017: Winner's ack is high during cycle k+2 (ACK) only; the other ack stays low.
REQ-018: Minimum spacing between two grants is 3 cycles; sustained throughput 1 write / 3 cycles.
REQ-019: Single request: granted immediately, regardless of owner history.
REQ-020: Simultaneous requests (default build): round-robin, requester not equal to o_owner wins.
REQ-021: o_owner updates at the grant edge to the winner.
REQ-022: Op value passed unmodified; op = 0 still runs ISSUE/ACK with o_op = 0 and ack given.
REQ-023: A request dropped before ack is a protocol violation; arbiter completes the grant with latched op/byte.
REQ-024: op/byte latched at grant edge; input changes after grant do not affect o_op/o_byte.

Reset
REQ-025: i_rst forces state IDLE, o_op = 0, o_byte = 0, o_busy = 0, both acks = 0, o_owner = 1.
REQ-026: Reset mid-operation (ISSUE or ACK) aborts the write; no ack is issued for it; o_op = 0 next cycle.
REQ-027: First tie after reset is won by CPU (o_owner = 1 at reset).
REQ-028: Reset has priority over all requests in the same cycle.

Configuration
REQ-029: Macro SFR_ARB_CPU_PRIO_EN defined: simultaneous requests always granted to CPU; o_owner still tracks winner.
REQ-030: Macro SFR_ARB_CPU_PRIO_EN undefined: round-robin per REQ-020.
REQ-031: Macro affects tie-break only; timing, FSM and reset identical in both builds.

Verification
REQ-032: Reset then cpu_req, op=OP_DMOD_WR_BYTE, byte=8'hA5 -> o_op=OP_DMOD_WR_BYTE, o_byte=A5 in cycle k+1, o_cpu_ack in k+2, DMOD reads A5.
REQ-033: Both requests held continuously (cpu byte 11, dbg byte 22), default build -> grants alternate CPU,DBG,CPU, o_byte 11,22,11 every 3 cycles.
REQ-034: Same stimulus with SFR_ARB_CPU_PRIO_EN, CPU reissuing immediately after each ack -> debug starved, only 8'h11 issued, o_dbg_ack never high.
REQ-035: dbg_req asserted during CPU ISSUE cycle -> dbg waits; o_op for dbg appears 2 cycles after CPU ack.
REQ-036: i_rst asserted in ISSUE cycle -> no ack, o_busy = 0 and o_op = 0 next cycle, o_owner = 1.
REQ-037: cpu_req with op=0, byte=FF -> o_op stays 0, o_cpu_ack pulses at k+2, DMOD unchanged.
